// File: rtl/linear_layer_fifo_pkg.sv
// Shared constants and helpers for the Linear_Layer dataflow FIFOs.
package linear_layer_fifo_pkg;

  // Default SRL depth for inter-process streams.
  localparam int FIFO_DEFAULT_DEPTH = 13;

  // Width of a start-token channel between dataflow processes.
  localparam int START_W = 1;

  // Ceiling log2, usable in constant expressions (returns 0 for value <= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/srl_fifo_fwft_shiftreg.sv
// Un-reset shift-register storage; new words enter at index 0, read is combinational.
module srl_fifo_fwft_shiftreg
  import linear_layer_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = FIFO_DEFAULT_DEPTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] sr [DEPTH];

  // Shift every entry up one slot on write; no reset so this maps onto SRL primitives.
  always_ff @(posedge clk) begin
    if (we) begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  // The controller only reads addresses below the current occupancy.
  assign dout = sr[addr];

endmodule

// File: rtl/srl_fifo_fwft.sv
// First-word-fall-through FIFO: SRL storage plus one registered head word.
// Capacity is DEPTH+1; the head register is refilled whenever it is empty or being popped.
module srl_fifo_fwft
  import linear_layer_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = FIFO_DEFAULT_DEPTH,
  parameter int AF_THRESH  = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_write,
  input  logic                  if_write_ce,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read,
  input  logic                  if_read_ce,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full,
  output logic                  err_ovf
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);

  logic [CW-1:0]         m_p0;      // SRL occupancy
  logic                  vld_p1;    // head register holds a word
  logic [DATA_WIDTH-1:0] dout_p1;   // head register
  logic                  err_q;

  logic                  push;
  logic                  pop;
  logic                  load;
  logic                  ovf_attempt;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] srl_dout;

  // Occupancy update; simultaneous push and load leave it unchanged.
  function automatic logic [CW-1:0] next_occ(input logic [CW-1:0] cur,
                                             input logic inc,
                                             input logic dec);
    logic [CW-1:0] r;
    r = cur;
    if (inc && !dec)      r = cur + 1'b1;
    else if (dec && !inc) r = cur - 1'b1;
    return r;
  endfunction

  // ---- stage p0: write side into the SRL ----
  assign if_full_n   = (m_p0 != DEPTH_C);
  assign push        = if_write & if_write_ce & if_full_n;
  assign ovf_attempt = if_write & if_write_ce & ~if_full_n;

  // Oldest word sits at index m-1; only meaningful while m > 0.
  assign rd_addr = ADDR_WIDTH'(m_p0 - 1'b1);

  srl_fifo_fwft_shiftreg #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_srl (
    .clk  (clk),
    .we   (push & ~reset),
    .addr (rd_addr),
    .din  (if_din),
    .dout (srl_dout)
  );

  // ---- stage p1: head register (first-word-fall-through) ----
  assign pop  = if_read & if_read_ce & vld_p1;
  assign load = (m_p0 != '0) & (~vld_p1 | pop);

  // Control state: occupancy, head-valid flag and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_p0   <= '0;
      vld_p1 <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      m_p0 <= next_occ(m_p0, push, load);
      if (load)      vld_p1 <= 1'b1;
      else if (pop)  vld_p1 <= 1'b0;
      if (ovf_attempt) err_q <= 1'b1;
    end
  end

  // Head data changes only on load or reset so if_dout never glitches on input X.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_p1 <= '0;
    end else if (load) begin
      dout_p1 <= srl_dout;
    end
  end

  // ---- outputs: decoded from registered state only ----
  assign if_dout     = dout_p1;
  assign if_empty_n  = vld_p1;
  assign count       = m_p0 + CW'(vld_p1);
  assign almost_full = (count >= AF_C);
  assign err_ovf     = err_q;

endmodule

// File: tb/tb_srl_fifo_fwft.sv
// Directed bench for srl_fifo_fwft: default build plus a 1-bit, depth-2 start-token build.
module tb_srl_fifo_fwft;

  logic        clk = 1'b0;
  logic        rst;

  logic        wr, wr_ce, rd, rd_ce;
  logic [31:0] din, dout;
  logic        full_n, empty_n, af, ovf;
  logic [4:0]  cnt;

  logic        w2, w2_ce, r2, r2_ce;
  logic [0:0]  din2, dout2;
  logic        full_n2, empty_n2, af2, ovf2;
  logic [1:0]  cnt2;

  logic [31:0] q1[$];
  logic        q2[$];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  srl_fifo_fwft dut (
    .clk(clk), .reset(rst),
    .if_write(wr), .if_write_ce(wr_ce), .if_din(din), .if_full_n(full_n),
    .if_read(rd), .if_read_ce(rd_ce), .if_dout(dout), .if_empty_n(empty_n),
    .count(cnt), .almost_full(af), .err_ovf(ovf)
  );

  srl_fifo_fwft #(.DATA_WIDTH(1), .ADDR_WIDTH(1), .DEPTH(2), .AF_THRESH(2)) dut2 (
    .clk(clk), .reset(rst),
    .if_write(w2), .if_write_ce(w2_ce), .if_din(din2), .if_full_n(full_n2),
    .if_read(r2), .if_read_ce(r2_ce), .if_dout(dout2), .if_empty_n(empty_n2),
    .count(cnt2), .almost_full(af2), .err_ovf(ovf2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: on the falling edge, any pop about to happen is checked against the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && rd && rd_ce && empty_n) begin
        if (q1.size() == 0) begin
          checks++; failures++;
          $display("FAIL mon_dout: got %0h expected no data", dout);
        end else begin
          chk("mon_dout", dout, q1.pop_front());
        end
      end
      if (!rst && r2 && r2_ce && empty_n2) begin
        if (q2.size() == 0) begin
          checks++; failures++;
          $display("FAIL mon_tok: got %0h expected no data", dout2);
        end else begin
          chk("mon_tok", dout2, q2.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; wr = 0; wr_ce = 1; din = 0; rd = 0; rd_ce = 1;
    w2 = 0; w2_ce = 1; din2 = 0; r2 = 0; r2_ce = 1;
    tick(); tick();
    rst = 0;

    // Reset state
    chk("rst_empty_n", empty_n, 0);
    chk("rst_full_n", full_n, 1);
    chk("rst_count", cnt, 0);
    chk("rst_af", af, 0);
    chk("rst_dout", dout, 0);
    chk("rst_ovf", ovf, 0);

    // Single write: visible one edge after acceptance
    wr = 1; din = 32'hA5A5_0001; q1.push_back(din);
    tick(); wr = 0;
    chk("t1_empty_n_e0", empty_n, 0);
    chk("t1_count_e0", cnt, 1);
    tick();
    chk("t1_empty_n_e1", empty_n, 1);
    chk("t1_dout_e1", dout, 32'hA5A5_0001);
    chk("t1_count_e1", cnt, 1);
    rd = 1; tick(); rd = 0;
    chk("t1_empty_after_rd", empty_n, 0);
    chk("t1_count_after_rd", cnt, 0);

    // Fill to capacity, overflow, then drain
    for (int k = 1; k <= 14; k++) begin
      wr = 1; din = k - 1; q1.push_back(din);
      tick();
      chk("t2_count", cnt, k);
      chk("t2_full_n", full_n, (k < 14));
      chk("t2_af", af, (k >= 11));
    end
    din = 32'h0000_0BAD; tick(); wr = 0;
    chk("t2_ovf", ovf, 1);
    chk("t2_count_full", cnt, 14);
    chk("t2_full_n_hold", full_n, 0);
    rd = 1; repeat (14) tick(); rd = 0;
    chk("t2_count_drained", cnt, 0);
    chk("t2_empty_drained", empty_n, 0);
    chk("t2_queue_left", q1.size(), 0);

    // Streaming: prime two words, then one in and one out every cycle
    wr = 1;
    for (int i = 0; i < 2; i++) begin
      din = i; q1.push_back(din); tick();
    end
    rd = 1;
    for (int i = 2; i < 100; i++) begin
      din = i; q1.push_back(din); tick();
      chk("t3_count_steady", cnt, 2);
      chk("t3_empty_n_steady", empty_n, 1);
    end
    wr = 0; tick(); tick(); rd = 0;
    chk("t3_count_end", cnt, 0);
    chk("t3_queue_left", q1.size(), 0);

    // Read while empty, write with ce low, read with ce low
    rd = 1; tick(); rd = 0;
    chk("t4_empty_rd_count", cnt, 0);
    chk("t4_empty_rd_empty_n", empty_n, 0);
    chk("t4_empty_rd_dout", dout, 99);
    wr = 1; wr_ce = 0; din = 32'hDEAD; tick(); wr = 0; wr_ce = 1;
    chk("t4_wce0_count", cnt, 0);
    chk("t4_wce0_empty_n", empty_n, 0);
    wr = 1; din = 32'h11; q1.push_back(din); tick();
    din = 32'h22; q1.push_back(din); tick(); wr = 0;
    chk("t4_count_two", cnt, 2);
    rd = 1; rd_ce = 0; tick(); tick(); rd = 0; rd_ce = 1;
    chk("t4_rce0_count", cnt, 2);
    chk("t4_rce0_dout", dout, 32'h11);

    // Start-token build: capacity 3, 4th token refused
    w2 = 1;
    din2 = 1'b1; q2.push_back(1'b1); tick();
    din2 = 1'b0; q2.push_back(1'b0); tick();
    chk("t6_full_n_two", full_n2, 1);
    chk("t6_count_two", cnt2, 2);
    din2 = 1'b1; q2.push_back(1'b1); tick();
    chk("t6_full_n_three", full_n2, 0);
    chk("t6_count_three", cnt2, 3);
    chk("t6_af", af2, 1);
    din2 = 1'b0; tick(); w2 = 0;
    chk("t6_ovf", ovf2, 1);
    chk("t6_count_after_ovf", cnt2, 3);
    r2 = 1; repeat (3) tick(); r2 = 0;
    chk("t6_count_drained", cnt2, 0);
    chk("t6_queue_left", q2.size(), 0);

    // Mid-stream reset with count 7 and sticky overflow set
    wr = 1;
    for (int i = 0; i < 5; i++) begin
      din = 32'h30 + i; q1.push_back(din); tick();
    end
    wr = 0;
    chk("t5_count_pre", cnt, 7);
    chk("t5_ovf_sticky", ovf, 1);
    rst = 1; wr = 1; din = 32'h55; rd = 1;
    q1.delete(); q2.delete();
    tick();
    rst = 0; wr = 0; rd = 0;
    chk("t5_count", cnt, 0);
    chk("t5_empty_n", empty_n, 0);
    chk("t5_full_n", full_n, 1);
    chk("t5_ovf", ovf, 0);
    chk("t5_dout", dout, 0);
    chk("t5_af", af, 0);
    wr = 1; din = 32'h77; q1.push_back(din); tick(); wr = 0;
    tick();
    rd = 1; tick(); rd = 0;
    chk("t5_post_queue_left", q1.size(), 0);
    chk("t5_post_count", cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/srl_fifo_fwft.md
Name: srl_fifo_fwft

Overview:
- Parametrised SRL-based FIFO: successor to the fixed 1-bit start-token shift register used between dataflow processes.
- Adds wide data, full/empty handshake, first-word-fall-through registered output, occupancy count, almost-full flag and a sticky overflow error.
- Sits on every inter-process stream and start channel of the Linear_Layer dataflow region.

Parameters:
- DATA_WIDTH, 32: payload width in bits (≥1).
- ADDR_WIDTH, 4: SRL address width; 2^ADDR_WIDTH ≥ DEPTH is required.
- DEPTH, 13: SRL entries (≥2). Total capacity = DEPTH+1, including the output register.
- AF_THRESH, 11: almost_full asserts when count ≥ AF_THRESH (1..DEPTH+1).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- if_write  in  1  write request.
- if_write_ce  in  1  write clock-enable; a write is ignored when 0.
- if_din  in  DATA_WIDTH  write data.
- if_full_n  out  1  1 = space available in SRL.
- if_read  in  1  read request.
- if_read_ce  in  1  read clock-enable.
- if_dout  out  DATA_WIDTH  head data (registered, FWFT).
- if_empty_n  out  1  1 = if_dout valid.
- count  out  ADDR_WIDTH+1  occupancy, 0..DEPTH+1.
- almost_full  out  1  count ≥ AF_THRESH.
- err_ovf  out  1  sticky: a write was attempted while full.

Behaviour:
- Definitions: push = if_write & if_write_ce & if_full_n; pop = if_read & if_read_ce & if_empty_n.
- State: m (SRL occupancy, 0..DEPTH), out_valid, out_reg, err_ovf.
- SRL: on push, shift every entry up one position and insert if_din at index 0. Read address = m-1, read combinationally.
- load = (m>0) & (!out_valid | pop). On load: out_reg ← SRL[m-1]; out_valid ← 1.
- pop without load: out_valid ← 0.
- Next m = m + push − load. When push and load coincide, m is unchanged; the read uses the pre-shift SRL contents.
- if_full_n = (m != DEPTH); if_empty_n = out_valid; if_dout = out_reg.
- count = m + out_valid. almost_full is decoded from registered state only. No output depends combinationally on an input.
- Latency:
  - Write accepted at edge E0 into an empty FIFO → if_empty_n=1 and if_dout valid after E1.
  - Back-to-back throughput is 1 word/cycle once primed.
- Full: if_full_n=0 when m=DEPTH, even if a load happens in the same cycle. The write is dropped and err_ovf ← 1. err_ovf stays set until reset.
- Empty: if_read while if_empty_n=0 is ignored; state and outputs are unchanged. No underflow flag.
- Ordering: strict FIFO order.
- Reset values: m=0, out_valid=0, out_reg=0, err_ovf=0. Therefore if_empty_n=0, if_full_n=1, count=0, almost_full=0 (AF_THRESH≥1), if_dout=0.
- SRL contents are not reset, to keep SRL inference. Reset asserted mid-stream discards all data on the next edge. Push and pop are ignored in the reset cycle.
- if_din/if_dout are X-safe: if_dout changes only on load or reset.

Decomposition:
- Shared package linear_layer_fifo_pkg holds:
  - clog2 function;
  - FIFO_DEFAULT_DEPTH=13;
  - start-token width constant START_W=1.
- Sub-module srl_fifo_fwft_shiftreg (parameters DATA_WIDTH, ADDR_WIDTH, DEPTH; ports clk, we, addr, din, dout):
  - un-reset SRL storage only;
  - the top level owns all control state.

Test Plan (default DATA_WIDTH=32, DEPTH=13, AF_THRESH=11):
- Reset, then single write of 0xA5A5_0001 at edge E0 → if_empty_n=0 after E0, =1 after E1; if_dout=0xA5A5_0001; count=1.
- 14 writes (0..13) with no reads → if_full_n drops after the 13th word enters the SRL; count=14; almost_full=1 from count 11; 15th write dropped, err_ovf=1; reading 14 words returns 0..13 in order.
- Continuous write and read, 100 words 0..99 after priming → one word per cycle, count stays constant, no gaps, order preserved.
- Read with if_read_ce=0, or read while empty → state unchanged; write with if_write_ce=0 → no push.
- Reset asserted with count=7 and err_ovf=1 → next cycle count=0, if_empty_n=0, if_full_n=1, err_ovf=0, if_dout=0.
- DATA_WIDTH=1, DEPTH=2 build (start-token mode): 3 tokens accepted, 4th refused (if_full_n=0), tokens drained in order.
